// File: rtl/regfile_pkg.sv
// regfile_pkg: shared index/word types and constants for the multiport register file.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_IDX = 0;
   localparam int MAX_RD_PORTS = 4;
   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
   typedef logic [DATA_W_DEF-1:0] reg_word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue/writeback priority and a registered busy count.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   issue_en,
   input  logic [ADDR_W-1:0]      issue_addr,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   output logic [2**ADDR_W-1:0]   busy,
   output logic [ADDR_W:0]        busy_cnt
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DEPTH-1:0] busy_nxt;
   logic [ADDR_W:0]  cnt_nxt;
   // issue is applied after the writeback clear so a new reservation wins a collision
   always_comb begin
      busy_nxt = busy;
      if (wr_en) busy_nxt[wr_addr] = 1'b0;
      if (issue_en) busy_nxt[issue_addr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[ZERO_IDX] = 1'b0;
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         busy_cnt <= '0;
      end else begin
         busy <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: clocked register file with NUM_RD async read ports, one write port and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the write port onto matching read ports in the same cycle.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
   output logic [NUM_RD-1:0]              rd_busy,
   input  logic                           wr_en,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic                           issue_en,
   input  logic [ADDR_W-1:0]              issue_addr,
   output logic [ADDR_W:0]                busy_cnt
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok;
   assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == ADDR_W'(ZERO_IDX));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end
   regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
      .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_addr(issue_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .busy_cnt(busy_cnt)
   );
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic zr;
      assign zr = ZERO_REG != 0 && rd_addr[g] == ADDR_W'(ZERO_IDX);
`ifdef REGFILE_BYPASS_EN
      logic fwd;
      // forwarding is held off during reset so reads stay 0 while rst_n is low
      assign fwd = rst_n && wr_en && rd_addr[g] == wr_addr && !zr;
      assign rd_data[g] = zr ? '0 : fwd ? wr_data : mem[rd_addr[g]];
      assign rd_busy[g] = zr || (fwd && !(issue_en && issue_addr == wr_addr)) ? 1'b0 : busy[rd_addr[g]];
`else
      assign rd_data[g] = zr ? '0 : mem[rd_addr[g]];
      assign rd_busy[g] = zr ? 1'b0 : busy[rd_addr[g]];
`endif
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed and random stimulus against an array-based model of the register file.
module tb_regfile_multiport;
   import regfile_pkg::*;
   localparam int NR = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NR-1:0][4:0]  rd_addr;
   logic [NR-1:0][31:0] rd_data;
   logic [NR-1:0]       rd_busy;
   logic                wr_en, issue_en;
   reg_idx_t            wr_addr, issue_addr;
   reg_word_t           wr_data;
   logic [5:0]          busy_cnt;
   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   reg_word_t m_reg [32];
   bit        m_busy [32];

   always #5 clk = ~clk;

   regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(NR), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_cnt();
      int n = 0;
      foreach (m_busy[i]) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic reg_word_t exp_data(input reg_idx_t a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && a == wr_addr) return wr_data;
`endif
      return m_reg[a];
   endfunction

   function automatic bit exp_busy(input reg_idx_t a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && a == wr_addr && !(issue_en && issue_addr == a)) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   // reference model: writeback clears, then a newer reservation sets; index 0 never changes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_reg[i]) begin
            m_reg[i] <= '0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         if (wr_en && wr_addr != 0) m_reg[wr_addr] <= wr_data;
         if (wr_en) m_busy[wr_addr] <= 1'b0;
         if (issue_en && issue_addr != 0) m_busy[issue_addr] <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int p = 0; p < NR; p++) begin
            check($sformatf("cyc rd_data[%0d]", p), 64'(rd_data[p]), 64'(exp_data(rd_addr[p])));
            check($sformatf("cyc rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(exp_busy(rd_addr[p])));
         end
         check("cyc busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0;
      issue_en = 1'b0;
   endtask

   initial begin
      idle();
      wr_addr = '0; issue_addr = '0; wr_data = '0;
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd31;
      step();
      chk_en = 1'b1;
      step();
      check("reset rd_data0", 64'(rd_data[0]), 64'h0);
      check("reset rd_data1", 64'(rd_data[1]), 64'h0);
      check("reset rd_busy", 64'(rd_busy), 64'h0);
      check("reset busy_cnt", 64'(busy_cnt), 64'h0);
      #2 rst_n = 1'b1;
      step();
      // write then read
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr[0] = 5'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("write cycle rd7", 64'(rd_data[0]), 64'hDEADBEEF);
`else
      check("write cycle rd7", 64'(rd_data[0]), 64'h0);
`endif
      step();
      idle();
      #1 check("after write rd7", 64'(rd_data[0]), 64'hDEADBEEF);
      // zero register
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; issue_en = 1'b1; issue_addr = 5'd0;
      step();
      idle();
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
      #1;
      check("zero rd_data", 64'(rd_data[0]), 64'h0);
      check("zero rd_busy", 64'(rd_busy[1]), 64'h0);
      check("zero busy_cnt", 64'(busy_cnt), 64'h0);
      // scoreboard lifecycle
      issue_en = 1'b1; issue_addr = 5'd3;
      step();
      check("issue3 busy_cnt", 64'(busy_cnt), 64'd1);
      issue_addr = 5'd9;
      step();
      check("issue9 busy_cnt", 64'(busy_cnt), 64'd2);
      issue_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
      step();
      idle();
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd9;
      #1;
      check("wb3 busy_cnt", 64'(busy_cnt), 64'd1);
      check("wb3 rd_busy3", 64'(rd_busy[0]), 64'd0);
      check("wb3 rd_busy9", 64'(rd_busy[1]), 64'd1);
      // collision on register 4
      issue_en = 1'b1; issue_addr = 5'd4;
      step();
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5A5A5;
      step();
      idle();
      rd_addr[0] = 5'd4;
      #1;
      check("collide data", 64'(rd_data[0]), 64'hA5A5A5A5);
      check("collide busy", 64'(rd_busy[0]), 64'd1);
      check("collide busy_cnt", 64'(busy_cnt), 64'd2);
      // randomized phase
      for (int n = 0; n < 1500; n++) begin
         wr_en = 1'($urandom_range(0, 1));
         issue_en = 1'($urandom_range(0, 1));
         wr_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         issue_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         wr_data = $urandom;
         for (int p = 0; p < NR; p++)
            rd_addr[p] = ($urandom_range(0, 2) == 0) ? wr_addr : ($urandom_range(0, 3) == 0) ? issue_addr : 5'($urandom_range(0, 31));
         step();
      end
      idle();
      step();
      // asynchronous reset mid-operation
      for (int r = 1; r <= 6; r++) begin
         issue_en = 1'b1; issue_addr = 5'(r);
         wr_en = 1'b1; wr_addr = 5'(r + 9); wr_data = 32'hC0DE0000 + 32'(r);
         step();
      end
      wr_en = 1'b1; wr_addr = 5'd12; issue_en = 1'b1; issue_addr = 5'd2;
      rd_addr[0] = 5'd1; rd_addr[1] = 5'd10;
      #1;
      check("pre-reset rd_busy1", 64'(rd_busy[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async rd_data", 64'(rd_data), 64'h0);
      check("async rd_busy", 64'(rd_busy), 64'h0);
      check("async busy_cnt", 64'(busy_cnt), 64'h0);
      step();
      @(posedge clk);
      #3 rst_n = 1'b1;
      idle();
      step();
      step();
      check("post-reset rd_data", 64'(rd_data), 64'h0);
      check("post-reset busy_cnt", 64'(busy_cnt), 64'h0);
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0BADF00D;
      step();
      idle();
      #1 check("post-reset write", 64'(rd_data[1]), 64'h0BADF00D);
      step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
